sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_pkg.sv | 20 ++
 rtl/sram_controller.sv | 131 +++++++++++++
 tb/tb_sram_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared state encoding and constants for the SRAM controller
package sram_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [31:0] MEM_BASE         = 32'd1024;
    localparam int unsigned SRAM_WAIT_CYCLES = 3;

    // Halfword address of one half of a 32-bit word; the offset wraps modulo the SRAM size.
    function automatic logic [17:0] sram_half_addr(input logic [31:0] byte_addr, input logic hi);
        return {17'((byte_addr - MEM_BASE) >> 2), hi};
    endfunction

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit access controller for a 16-bit asynchronous SRAM
module sram_controller
    import sram_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEn,
    input  logic        wrEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ_in,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_WE_N
);

    state_t      state_q, state_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;
    logic        we_n_q, we_n_d;
    logic        req;

    assign req = rdEn | wrEn;

    // Bus pins are registered from the next state so they are stable for the whole LO/HI cycle.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_LO;
                    addr_d      = address;
                    wdata_d     = writeData;
                    is_write_d  = wrEn;
                    sram_addr_d = sram_half_addr(address, 1'b0);
                    if (wrEn) begin
                        dq_out_d = writeData[15:0];
                        dq_oe_d  = 1'b1;
                        we_n_d   = 1'b0;
                    end
                end
            end
            ST_LO: begin
                state_d     = ST_HI;
                sram_addr_d = sram_half_addr(addr_q, 1'b1);
                if (is_write_q) begin
                    dq_out_d = wdata_q[31:16];
                    dq_oe_d  = 1'b1;
                    we_n_d   = 1'b0;
                end else begin
                    rdata_d[15:0] = SRAM_DQ_in;
                end
            end
            ST_HI: begin
                state_d    = ST_WAIT;
                wait_cnt_d = 2'd0;
                if (!is_write_q) begin
                    rdata_d[31:16] = SRAM_DQ_in;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 2'(SRAM_WAIT_CYCLES - 1)) begin
                    state_d    = ST_DONE;
                    wait_cnt_d = 2'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 2'd0;
            is_write_q  <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            sram_addr_q <= 18'd0;
            dq_out_q    <= 16'd0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    // Combinational so the pipeline freezes in the same cycle the request appears.
    assign ready       = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
    assign readData    = rdata_q;
    assign SRAM_ADDR   = sram_addr_q;
    assign SRAM_DQ_out = dq_out_q;
    assign SRAM_DQ_oe  = dq_oe_q;
    assign SRAM_WE_N   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - randomized self-checking bench with a word-level reference model
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdEn;
    logic        wrEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic        SRAM_WE_N;

    int checks = 0;
    int errors = 0;

    logic [15:0] sram_model [0:262143];
    logic [15:0] ref_mem [int];
    logic [31:0] ref_rdata;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        b2b;
    } op_t;
    op_t ops[$];

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rdEn       (rdEn),
        .wrEn       (wrEn),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_in (SRAM_DQ_in),
        .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_oe (SRAM_DQ_oe),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    always #5 clk = ~clk;

    assign SRAM_DQ_in = sram_model[SRAM_ADDR];
    always @(posedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_oe) sram_model[SRAM_ADDR] <= SRAM_DQ_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] exp_half(input logic [31:0] a);
        int unsigned word;
        word = (a - 32'd1024) / 4;
        return 18'((word % 131072) * 2);
    endfunction

    function automatic logic [15:0] ref_get(input int idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return 16'd0;
    endfunction

    // Called mid-cycle with the DUT in IDLE; returns mid-cycle n+7 with the n+1.. inputs applied.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic nrd, input logic nwr,
                             input logic [31:0] na, input logic [31:0] nwd);
        logic [7:0]  rdy_v, we_v, oe_v, exp_rdy, exp_we;
        logic [17:0] a_lo, a_hi, h;
        logic [15:0] d_lo, d_hi;
        logic [31:0] rd_at6;
        h = exp_half(a);
        a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0; rd_at6 = '0;
        rdEn = rd; wrEn = wr; address = a; writeData = wd;
        #1;
        rdy_v[0] = ready; we_v[0] = !SRAM_WE_N; oe_v[0] = SRAM_DQ_oe;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            rdEn = nrd; wrEn = nwr; address = na; writeData = nwd;
            @(negedge clk);
            rdy_v[c] = ready; we_v[c] = !SRAM_WE_N; oe_v[c] = SRAM_DQ_oe;
            if (c == 1) begin a_lo = SRAM_ADDR; d_lo = SRAM_DQ_out; end
            if (c == 2) begin a_hi = SRAM_ADDR; d_hi = SRAM_DQ_out; end
            if (c == 6) rd_at6 = readData;
        end
        if (wr) begin
            ref_mem[int'(h)]     = wd[15:0];
            ref_mem[int'(h) + 1] = wd[31:16];
        end else begin
            ref_rdata = {ref_get(int'(h) + 1), ref_get(int'(h))};
        end
        exp_rdy = {~(nrd | nwr), 1'b1, 6'b0};
        exp_we  = wr ? 8'b0000_0110 : 8'b0;
        check({tag, ".ready"}, 32'(rdy_v), 32'(exp_rdy));
        check({tag, ".we"}, 32'(we_v), 32'(exp_we));
        check({tag, ".oe"}, 32'(oe_v), 32'(exp_we));
        check({tag, ".addr_lo"}, 32'(a_lo), 32'(h));
        check({tag, ".addr_hi"}, 32'(a_hi), 32'(h) + 32'd1);
        check({tag, ".rdata"}, rd_at6, ref_rdata);
        if (wr) begin
            check({tag, ".dq"}, {d_hi, d_lo}, wd);
            check({tag, ".mem_lo"}, 32'(sram_model[int'(h)]), 32'(ref_get(int'(h))));
            check({tag, ".mem_hi"}, 32'(sram_model[int'(h) + 1]), 32'(ref_get(int'(h) + 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t cur, nxt;
        ref_rdata = 32'd0;
        rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0; address = 32'd0; writeData = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.ready", 32'(ready), 32'd1);
        check("rst.we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst.oe", 32'(SRAM_DQ_oe), 32'd0);
        check("rst.rdata", readData, 32'd0);
        check("rst.addr", 32'(SRAM_ADDR), 32'd0);
        check("rst.dq", 32'(SRAM_DQ_out), 32'd0);

        do_access("wr1024", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0);
        check("wr1024.sram0", 32'(sram_model[0]), 32'h0000BEEF);
        check("wr1024.sram1", 32'(sram_model[1]), 32'h0000DEAD);
        do_access("rd1024", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("rd1024.value", readData, 32'hDEADBEEF);

        do_access("wr1032", 1'b0, 1'b1, 32'd1032, 32'h12345678, 1'b1, 1'b0, 32'd1032, 32'd0);
        do_access("rd1032", 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("rd1032.value", readData, 32'h12345678);

        do_access("both1028", 1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 1'b0, 1'b0, 32'd0, 32'd0);
        check("both1028.keep", readData, 32'h12345678);

        // Reset lands on the edge that would start the high half of the write.
        wrEn = 1'b1; address = 32'd1028; writeData = 32'hCAFEF00D;
        @(posedge clk);
        #1 wrEn = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        ref_mem[2] = 16'hF00D;
        ref_rdata  = 32'd0;
        check("rst_mid.we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_mid.oe", 32'(SRAM_DQ_oe), 32'd0);
        check("rst_mid.ready", 32'(ready), 32'd1);
        check("rst_mid.rdata", readData, 32'd0);
        check("rst_mid.half1", 32'(sram_model[3]), 32'h0000A5A5);
        check("rst_mid.half0", 32'(sram_model[2]), 32'h0000F00D);
        repeat (8) begin
            @(negedge clk);
            check("rst_mid.idle", 32'(ready), 32'd1);
        end

        do_access("wr0", 1'b0, 1'b1, 32'd0, $urandom, 1'b0, 1'b0, 32'd0, 32'd0);
        do_access("rd0drop", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, $urandom, $urandom);
        check("rd0drop.addr", 32'(exp_half(32'd0)), 32'h0003FE00);

        for (int k = 0; k < 8; k++) begin
            do_access("fill", 1'b0, 1'b1, 32'd1024 + 32'(4 * k), $urandom, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        for (int i = 0; i < 24; i++) begin
            int unsigned kind;
            kind = $urandom % 3;
            cur.rd  = (kind != 1);
            cur.wr  = (kind != 0);
            cur.a   = 32'd1024 + 32'(4 * ($urandom % 8)) + 32'($urandom % 4);
            cur.d   = $urandom;
            cur.b2b = ($urandom % 3) == 0;
            ops.push_back(cur);
        end
        for (int i = 0; i < ops.size(); i++) begin
            if (ops[i].b2b && (i + 1) < ops.size()) begin
                nxt = ops[i + 1];
            end else begin
                nxt.rd = 1'b0; nxt.wr = 1'b0; nxt.a = $urandom; nxt.d = $urandom; nxt.b2b = 1'b0;
            end
            do_access("rand", ops[i].rd, ops[i].wr, ops[i].a, ops[i].d, nxt.rd, nxt.wr, nxt.a, nxt.d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
